// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states and the latched request.
package lsu_pkg;

  localparam int unsigned XLEN_W = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_RD   = 2'd1,
    LSU_WR   = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic              store;
    logic [1:0]        size;
    logic              is_unsigned;
    logic [XLEN_W-1:0] addr;
    logic [XLEN_W-1:0] wdata;
  } lsu_req_t;

  // Size code 11 behaves as a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: misalign check, load extraction/extension, subword store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        addr,
  input  logic [XLEN_W-1:0] wdata,
  input  logic [XLEN_W-1:0] rword,
  output logic              misalign_c,
  output logic [XLEN_W-1:0] load_c,
  output logic [XLEN_W-1:0] merge_c
);

  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    misalign_c = 1'b0;
    if (size == SZ_H) begin
      misalign_c = addr[0];
    end else if (is_word(size)) begin
      misalign_c = (addr != 2'b00);
    end

    b_lane  = 8'(rword >> {addr, 3'b000});
    h_lane  = 16'(rword >> {addr[1], 4'b0000});
    load_c  = rword;
    merge_c = wdata;

    // Word accesses pass through untouched: read word for loads, store data for writes.
    case (size)
      SZ_B: begin
        load_c  = is_unsigned ? {24'b0, b_lane} : {{24{b_lane[7]}}, b_lane};
        merge_c = rword;
        merge_c[{addr, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_c  = is_unsigned ? {16'b0, h_lane} : {{16{h_lane[15]}}, h_lane};
        merge_c = rword;
        merge_c[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: one request at a time, word-wide cache port, RMW for SB/SH.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter bit          MISALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misalign,
  output logic            dc_r_enable,
  output logic [XLEN-1:0] dc_r_addr,
  input  logic [XLEN-1:0] dc_r_data,
  output logic            dc_w_enable,
  output logic [XLEN-1:0] dc_w_addr,
  output logic [XLEN-1:0] dc_w_data
);

  lsu_state_e state_q, state_d;
  lsu_req_t   req_q, req_d, in_req;

  logic [XLEN_W-1:0] in_addr;
  logic [1:0]        al_size;
  logic              al_uns;
  logic [1:0]        al_addr;
  logic [XLEN_W-1:0] al_wdata;
  logic              misalign_c, miss_c, miss_d;
  logic [XLEN_W-1:0] load_c, merge_c;

  logic              ready_d, rv_d, ren_d, wen_d, mis_d;
  logic [XLEN_W-1:0] raddr_d, waddr_d, wdata_d, rdata_d;

  // With the check disabled, offending low address bits are cleared before latching.
  always_comb begin
    in_addr = req_addr;
    if (!MISALIGN_CHECK) begin
      if (req_size == SZ_H) begin
        in_addr[0] = 1'b0;
      end else if (is_word(req_size)) begin
        in_addr[1:0] = 2'b00;
      end
    end
    in_req = '{store: req_store, size: req_size, is_unsigned: req_unsigned,
               addr: in_addr, wdata: req_wdata};
  end

  // The aligner looks at the incoming request in IDLE and the latched one otherwise.
  always_comb begin
    if (state_q == LSU_IDLE) begin
      al_size  = req_size;
      al_uns   = req_unsigned;
      al_addr  = req_addr[1:0];
      al_wdata = req_wdata;
    end else begin
      al_size  = req_q.size;
      al_uns   = req_q.is_unsigned;
      al_addr  = req_q.addr[1:0];
      al_wdata = req_q.wdata;
    end
  end

  lsu_align u_align (
    .size        (al_size),
    .is_unsigned (al_uns),
    .addr        (al_addr),
    .wdata       (al_wdata),
    .rword       (dc_r_data),
    .misalign_c  (misalign_c),
    .load_c      (load_c),
    .merge_c     (merge_c)
  );

  assign miss_c = MISALIGN_CHECK && misalign_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LSU_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    miss_d  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          req_d  = in_req;
          miss_d = miss_c;
          if (miss_c) begin
            state_d = LSU_RESP;
          end else if (req_store && is_word(req_size)) begin
            state_d = LSU_WR;
          end else begin
            state_d = LSU_RD;
          end
        end
      end
      LSU_RD:   state_d = req_q.store ? LSU_WR : LSU_RESP;
      LSU_WR:   state_d = LSU_RESP;
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase

    ready_d = (state_d == LSU_IDLE);
    rv_d    = (state_d == LSU_RESP);
    ren_d   = (state_d == LSU_RD);
    wen_d   = (state_d == LSU_WR);
    raddr_d = ren_d ? {req_d.addr[XLEN_W-1:2], 2'b00} : '0;
    waddr_d = wen_d ? {req_d.addr[XLEN_W-1:2], 2'b00} : '0;
    wdata_d = wen_d ? merge_c : '0;
    rdata_d = resp_rdata;
    mis_d   = resp_misalign;
    if (rv_d) begin
      mis_d   = miss_d;
      rdata_d = (state_q == LSU_RD) ? load_c : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      dc_r_enable   <= 1'b0;
      dc_r_addr     <= '0;
      dc_w_enable   <= 1'b0;
      dc_w_addr     <= '0;
      dc_w_data     <= '0;
    end else begin
      req_ready     <= ready_d;
      resp_valid    <= rv_d;
      resp_rdata    <= rdata_d;
      resp_misalign <= mis_d;
      dc_r_enable   <= ren_d;
      dc_r_addr     <= raddr_d;
      dc_w_enable   <= wen_d;
      dc_w_addr     <= waddr_d;
      dc_w_data     <= wdata_d;
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the MEM stage: accepts one memory request at a time from the pipeline and drives the word-wide data cache port. Subword stores (SB/SH) become read-modify-write sequences, because the cache writes whole 32-bit words with no byte enables. Loads are extracted from the cache word and sign- or zero-extended. Misaligned accesses are detected before any cache access is made.

## Interface
Parameters:
- `XLEN`, 32: data and address width. Only 32 is supported.
- `MISALIGN_CHECK`, 1: when 1, misaligned accesses are flagged and dropped. When 0, the offending low address bits are forced to zero and the access proceeds.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU can accept a request; 1 only in IDLE.
- `req_store`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `req_unsigned`  in  1  zero-extend a load (LBU/LHU).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_misalign`  out  1  request was misaligned and dropped; qualified by `resp_valid`.
- `dc_r_enable`  out  1  cache read strobe.
- `dc_r_addr`  out  32  cache read address, word-aligned.
- `dc_r_data`  in  32  cache read data, combinational from `dc_r_addr`.
- `dc_w_enable`  out  1  cache write strobe.
- `dc_w_addr`  out  32  cache write address, word-aligned.
- `dc_w_data`  out  32  full cache word to write.

## Operation
- Handshake: a request is accepted on a rising edge with `req_valid && req_ready`. Its fields are latched into a request register and are not sampled again. There is no backpressure on the response; the consumer must take `resp_valid` when it pulses.
- States: IDLE, RD, WR, RESP.
- From IDLE on accept:
  - misaligned → RESP;
  - load → RD;
  - word store → WR;
  - byte/half store → RD.
- Misaligned means `size==half && addr[0]`, or `size==word && addr[1:0]!=0`. This check applies only when `MISALIGN_CHECK=1`.
- RD: assert `dc_r_enable` with `dc_r_addr = {addr[31:2],2'b00}`.
  - Load: register the extracted, extended lane into `resp_rdata`, then → RESP.
  - Subword store: register merged word = `dc_r_data` with the selected lane replaced by `req_wdata[7:0]` or `[15:0]`, then → WR.
- Lane select: byte uses `addr[1:0]`, so lane 0 = bits [7:0]. Half uses `addr[1]`.
- WR: assert `dc_w_enable` with `dc_w_addr` word-aligned. `dc_w_data` is the merged word for subword stores, or `req_wdata` for word stores. Then → RESP.
- RESP: `resp_valid=1` for exactly one cycle, then → IDLE.
- Enable exclusivity: `dc_r_enable` and `dc_w_enable` are never high in the same cycle. Both are 0 in IDLE and RESP.
- Idle cache drive: when not asserted, `dc_*_addr` and `dc_w_data` are driven 0.
- Word loads ignore `req_unsigned`.

## Timing
- Reset values: state = IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_misalign=0`, all `dc_*` outputs 0, request and merge registers 0.
- Latency in cycles after the accept edge, counted to the cycle in which `resp_valid` is high:
  - misaligned: 1;
  - word store: 2;
  - load: 2;
  - subword store: 3.
- Throughput: one request every latency+1 cycles. `req_ready` is low from the cycle after accept through RESP.
- Back-to-back: a request presented during RESP is not accepted. It is accepted on the first IDLE edge.
- Reset mid-operation: asynchronous return to IDLE. No pending write is issued and the latched request is discarded. A write whose WR cycle is cut by reset may or may not land, and the bench must not check it.
- `resp_rdata` and `resp_misalign` are registered and hold their values until the next RESP. They are meaningful only while `resp_valid=1`.

## Structure
- `lsu_pkg`: size encoding constants (`SZ_B`, `SZ_H`, `SZ_W`), the state enum (`LSU_IDLE`, `LSU_RD`, `LSU_WR`, `LSU_RESP`), and the request struct (store, size, unsigned, addr, wdata).
- Sub-module `lsu_align` (combinational) implements load lane extraction with sign/zero extension, store lane merge, and the misalign check. The FSM and registers stay in `lsu`.

## Test plan
- Word store then load: SW 0xDEADBEEF @0x100, then LW @0x100.
  - SW: `dc_w_enable` asserted once with addr 0x100 and data 0xDEADBEEF.
  - LW: `resp_rdata=0xDEADBEEF`, returned 2 cycles after accept.
- Byte store merge: memory word @0x104 = 0x11223344, then SB 0xAA @0x106. Required: one RD cycle, then one WR cycle with `dc_w_data=0x11AA3344`, then `resp_valid` in the 3rd cycle after accept.
- Load extension on word @0x108 = 0x80F0_7F85:
  - LB @0x108 → 0xFFFFFF85;
  - LBU @0x108 → 0x00000085;
  - LH @0x10A → 0xFFFF80F0;
  - LHU @0x10A → 0x000080F0.
- Misalign with `MISALIGN_CHECK=1`: LW @0x101 and SH @0x103. Each gives `resp_valid`+`resp_misalign`=1 one cycle after accept, with no `dc_r_enable` or `dc_w_enable` pulse.
- Handshake: hold `req_valid` high continuously with alternating SW/LW. `req_ready` falls after each accept, exactly one request is accepted per IDLE, and `dc_r_enable` and `dc_w_enable` are never high together.
- Reset mid-RMW: deassert `rst` during the RD cycle of an SH. Required: outputs are at their reset values immediately (asynchronously), no `dc_w_enable` pulse follows, and the next request is accepted normally.
